shift_add_mult: RTL

//  Sequential unsigned shift-and-add multiplier. It takes two n-bit operands on a

---
 rtl/shift_add_mult_if.sv | 20 ++
 rtl/shift_add_mult.sv | 88 ++++++++
 2 files changed

// File: rtl/shift_add_mult_if.sv
// Operand/result bundle for shift_add_mult.
//
// Handshake: the master raises start with DataA/DataB valid. The multiplier
// samples them on the first posedge it sees start=1 while idle. busy stays high
// while the product is being built. done rises once P is final and stays high
// until start is low at a posedge. A new operation therefore needs start low for
// at least one edge and then high again. A start held high never retriggers.
interface shift_add_mult_if #(
  parameter int n = 8
);
  logic           start;
  logic [n-1:0]   DataA;
  logic [n-1:0]   DataB;
  logic [2*n-1:0] P;
  logic           busy;
  logic           done;

  modport master (output start, DataA, DataB, input P, busy, done);
  modport slave  (input start, DataA, DataB, output P, busy, done);
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier with an n-bit by n-bit operand
// and a 2n-bit product.
//
// The operation is one conditional add per clock. The multiplicand shifts left
// and the multiplier shifts right. The build-time macro SHIFT_ADD_MULT_EARLY_EXIT_EN
// ends the calculation once the remaining multiplier bits are all zero. It does
// not change the product.
//
// The interface instance connected to mult must use the same n as this module.
module shift_add_mult #(
  parameter int n = 8
) (
  input  logic              clock,
  input  logic              resetn,
  shift_add_mult_if.slave   mult,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(n) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q;
  logic [2*n-1:0] a_q;
  logic [n-1:0]   b_q;
  logic [2*n-1:0] p_q;
  logic [CW-1:0]  count_q;

  // Controller and datapath. Each posedge in S_CALC does one iteration.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mult.start) begin
            a_q     <= {{n{1'b0}}, mult.DataA};
            b_q     <= mult.DataB;
            p_q     <= '0;
            count_q <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (b_q[0]) begin
            p_q <= p_q + a_q;
          end
          a_q     <= a_q << 1;
          b_q     <= b_q >> 1;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(n - 1)) begin
            state_q <= S_DONE;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
          end else if ((b_q >> 1) == '0) begin
            // No multiplier bits are left, so later iterations would add nothing.
            state_q <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          // Hold while start stays high so a held request cannot retrigger.
          if (!mult.start) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded from the registered state only.
  always_comb begin
    mult.busy = (state_q == S_CALC);
    mult.done = (state_q == S_DONE);
  end

  assign mult.P    = p_q;
  assign state_dbg = state_q;

endmodule
